// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode
//  Purpose  : Decode stage between instr_fetch and execute. Splits a 32-bit
//             instruction into fields, builds the sign-extended immediate,
//             classifies it (scalar / vector / illegal) and hands a registered
//             bundle downstream through a 2-entry skid buffer.
//  Options  : ID_ILLEGAL_TRAP_EN - stop accepting after an illegal bundle
//             transfers out, until flush or reset.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_decode #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  if_valid,
   output logic                  if_ready,
   input  logic [DATA_WIDTH-1:0] if_instr,
   input  logic [DATA_WIDTH-1:0] if_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] id_pc,
   output logic [6:0]            id_opcode,
   output logic [4:0]            id_rd,
   output logic [2:0]            id_funct3,
   output logic [4:0]            id_rs1,
   output logic [4:0]            id_rs2,
   output logic [6:0]            id_funct7,
   output logic [DATA_WIDTH-1:0] id_imm,
   output logic                  id_is_vector,
   output logic                  id_reg_write,
   output logic                  id_mem_read,
   output logic                  id_mem_write,
   output logic                  id_branch,
   output logic                  id_jump,
   output logic                  id_illegal
);

   localparam logic [6:0] OPC_OP       = 7'h33;
   localparam logic [6:0] OPC_OP_IMM   = 7'h13;
   localparam logic [6:0] OPC_LOAD     = 7'h03;
   localparam logic [6:0] OPC_STORE    = 7'h23;
   localparam logic [6:0] OPC_BRANCH   = 7'h63;
   localparam logic [6:0] OPC_JAL      = 7'h6F;
   localparam logic [6:0] OPC_JALR     = 7'h67;
   localparam logic [6:0] OPC_LUI      = 7'h37;
   localparam logic [6:0] OPC_AUIPC    = 7'h17;
   localparam logic [6:0] OPC_OP_V     = 7'h57;
   localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
   localparam logic [6:0] OPC_STORE_FP = 7'h27;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [6:0]            opcode;
      logic [4:0]            rd;
      logic [2:0]            funct3;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [6:0]            funct7;
      logic [DATA_WIDTH-1:0] imm;
      logic                  is_vector;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic                  jump;
      logic                  illegal;
   } bundle_t;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } state_t;

   bundle_t w_dec;
   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_v_q, main_v_d, skid_v_q, skid_v_d;
   state_t  state_q, state_d;
   logic    w_vec_width;
   logic    w_xfer_in;
   logic    w_consume;

   // LOAD-FP/STORE-FP widths that select the vector memory encoding
   assign w_vec_width = (if_instr[14:12] == 3'b000) || (if_instr[14:12] == 3'b101) ||
                        (if_instr[14:12] == 3'b110) || (if_instr[14:12] == 3'b111);

   // Combinational decode of the incoming instruction word
   always_comb begin
      w_dec        = '0;
      w_dec.pc     = if_pc;
      w_dec.opcode = if_instr[6:0];
      w_dec.rd     = if_instr[11:7];
      w_dec.funct3 = if_instr[14:12];
      w_dec.rs1    = if_instr[19:15];
      w_dec.rs2    = if_instr[24:20];
      w_dec.funct7 = if_instr[31:25];
      if (if_instr[1:0] != 2'b11) begin
         w_dec.illegal = 1'b1;
      end else begin
         case (if_instr[6:0])
            OPC_OP:       w_dec.reg_write = 1'b1;
            OPC_OP_IMM: begin
               w_dec.reg_write = 1'b1;
               w_dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_LOAD: begin
               w_dec.reg_write = 1'b1;
               w_dec.mem_read  = 1'b1;
               w_dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_STORE: begin
               w_dec.mem_write = 1'b1;
               w_dec.imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OPC_BRANCH: begin
               w_dec.branch = 1'b1;
               w_dec.imm    = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                               if_instr[11:8], 1'b0};
            end
            OPC_JAL: begin
               w_dec.reg_write = 1'b1;
               w_dec.jump      = 1'b1;
               w_dec.imm       = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                                  if_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
               w_dec.reg_write = 1'b1;
               w_dec.jump      = 1'b1;
               w_dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_LUI, OPC_AUIPC: begin
               w_dec.reg_write = 1'b1;
               w_dec.imm       = {if_instr[31:12], 12'b0};
            end
            OPC_OP_V: begin
               w_dec.reg_write = 1'b1;
               w_dec.is_vector = 1'b1;
            end
            OPC_LOAD_FP: begin
               w_dec.reg_write = 1'b1;
               w_dec.mem_read  = 1'b1;
               w_dec.is_vector = w_vec_width;
               w_dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_STORE_FP: begin
               w_dec.mem_write = 1'b1;
               w_dec.is_vector = w_vec_width;
               w_dec.imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            default: w_dec.illegal = 1'b1;
         endcase
      end
      // x0 is never written by scalar classes; vector rd names v0, a real register
      if (w_dec.reg_write && !w_dec.is_vector && (w_dec.rd == 5'd0)) begin
         w_dec.reg_write = 1'b0;
      end
   end

   // Handshake terms; flush forces ready so the incoming word is visibly dropped
   assign if_ready  = flush || (!skid_v_q && (state_q == ST_RUN));
   assign id_valid  = main_v_q && (state_q == ST_RUN);
   assign w_xfer_in = if_valid && !skid_v_q && (state_q == ST_RUN);
   assign w_consume = id_valid && id_ready;

   // Skid-buffer and trap next-state; flush overrides everything
   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      state_d  = state_q;
      if (flush) begin
         main_d   = '0;
         skid_d   = '0;
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
         state_d  = ST_RUN;
      end else if (w_consume) begin
         if (skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = w_xfer_in;
            if (w_xfer_in) skid_d = w_dec;
         end else begin
            main_v_d = w_xfer_in;
            if (w_xfer_in) main_d = w_dec;
         end
`ifdef ID_ILLEGAL_TRAP_EN
         if (main_q.illegal) state_d = ST_TRAP;
`else
         state_d = ST_RUN;
`endif
      end else if (w_xfer_in) begin
         if (main_v_q) begin
            skid_d   = w_dec;
            skid_v_d = 1'b1;
         end else begin
            main_d   = w_dec;
            main_v_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         state_q  <= ST_RUN;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         state_q  <= state_d;
      end
   end

   assign id_pc        = main_q.pc;
   assign id_opcode    = main_q.opcode;
   assign id_rd        = main_q.rd;
   assign id_funct3    = main_q.funct3;
   assign id_rs1       = main_q.rs1;
   assign id_rs2       = main_q.rs2;
   assign id_funct7    = main_q.funct7;
   assign id_imm       = main_q.imm;
   assign id_is_vector = main_q.is_vector;
   assign id_reg_write = main_q.reg_write;
   assign id_mem_read  = main_q.mem_read;
   assign id_mem_write = main_q.mem_write;
   assign id_branch    = main_q.branch;
   assign id_jump      = main_q.jump;
   assign id_illegal   = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_decode
//  Purpose  : Directed self-checking bench for instr_decode. Honours
//             ID_ILLEGAL_TRAP_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

   logic        clk, rst, flush, if_valid, if_ready, id_valid, id_ready;
   logic [31:0] if_instr, if_pc, id_pc, id_imm;
   logic [6:0]  id_opcode, id_funct7;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [2:0]  id_funct3;
   logic        id_is_vector, id_reg_write, id_mem_read, id_mem_write;
   logic        id_branch, id_jump, id_illegal;
   int          n_checks, n_fail;

   instr_decode #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_opcode(id_opcode), .id_rd(id_rd), .id_funct3(id_funct3),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct7(id_funct7), .id_imm(id_imm),
      .id_is_vector(id_is_vector), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %0h want 0", id_valid); end
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %0h want 1", if_ready); end
      n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %08h want 0", id_pc); end
      n_checks++; if (id_imm !== 32'h0) begin n_fail++; $display("FAIL reset_id_imm: got %08h want 0", id_imm); end
      n_checks++; if ({id_reg_write, id_illegal, id_rd} !== 7'h0) begin n_fail++; $display("FAIL reset_fields: got %0h want 0", {id_reg_write, id_illegal, id_rd}); end
      rst = 1'b1;
   endtask

   task automatic test_single();
      id_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h0;
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0h want 1", id_valid); end
      n_checks++; if (id_rd !== 5'd1) begin n_fail++; $display("FAIL single_rd: got %0d want 1", id_rd); end
      n_checks++; if (id_imm !== 32'd5) begin n_fail++; $display("FAIL single_imm: got %08h want 5", id_imm); end
      n_checks++; if (id_reg_write !== 1'b1) begin n_fail++; $display("FAIL single_reg_write: got %0h want 1", id_reg_write); end
      n_checks++; if (id_is_vector !== 1'b0) begin n_fail++; $display("FAIL single_is_vector: got %0h want 0", id_is_vector); end
      n_checks++; if (id_opcode !== 7'h13) begin n_fail++; $display("FAIL single_opcode: got %02h want 13", id_opcode); end
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0h want 0", id_valid); end
   endtask

   task automatic test_back_to_back();
      id_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if_valid = 1'b1;
         if_instr = 32'h0000_0013 | ((i + 1) << 7);
         if_pc    = i * 4;
         n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_if_ready[%0d]: got %0h want 1", i, if_ready); end
         @(posedge clk); #1;
         n_checks++; if (id_valid !== 1'b1 || id_pc !== i * 4 || id_rd !== 5'(i + 1)) begin
            n_fail++; $display("FAIL b2b_out[%0d]: got valid=%0h pc=%08h rd=%0d want valid=1 pc=%08h rd=%0d", i, id_valid, id_pc, id_rd, i * 4, i + 1);
         end
      end
      if_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h want 0", id_valid); end
   endtask

   task automatic test_backpressure();
      id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h0000_0293; if_pc = 32'h100;
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL bp_first: got valid=%0h pc=%08h want valid=1 pc=100", id_valid, id_pc); end
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_1: got %0h want 1", if_ready); end
      if_instr = 32'h0000_0313; if_pc = 32'h104;
      @(posedge clk); #1;
      n_checks++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL bp_hold_a: got %08h want 100", id_pc); end
      n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %0h want 0", if_ready); end
      if_instr = 32'h0000_0393; if_pc = 32'h108;
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || if_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_third_refused: got valid=%0h pc=%08h rdy=%0h want 1 100 0", id_valid, id_pc, if_ready);
      end
      id_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h104 || if_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_out_b: got valid=%0h pc=%08h rdy=%0h want 1 104 1", id_valid, id_pc, if_ready);
      end
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h108 || id_rd !== 5'd7) begin
         n_fail++; $display("FAIL bp_out_c: got valid=%0h pc=%08h rd=%0d want 1 108 7", id_valid, id_pc, id_rd);
      end
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %0h want 0", id_valid); end
   endtask

   task automatic test_immediates();
      id_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFE00_0EE3; if_pc = 32'h200;
      @(posedge clk); #1;
      n_checks++; if (id_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL beq_imm: got %08h want fffffffc", id_imm); end
      n_checks++; if (id_branch !== 1'b1 || id_reg_write !== 1'b0) begin n_fail++; $display("FAIL beq_ctrl: got br=%0h rw=%0h want 1 0", id_branch, id_reg_write); end
      if_instr = 32'h8000_00EF; if_pc = 32'h204;
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_imm !== 32'hFFF0_0000) begin n_fail++; $display("FAIL jal_imm: got %08h want fff00000", id_imm); end
      n_checks++; if (id_jump !== 1'b1 || id_reg_write !== 1'b1 || id_branch !== 1'b0) begin n_fail++; $display("FAIL jal_ctrl: got j=%0h rw=%0h br=%0h want 1 1 0", id_jump, id_reg_write, id_branch); end
      @(posedge clk); #1;
   endtask

   task automatic test_vector_illegal();
      id_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h0220_8057; if_pc = 32'h300;
      @(posedge clk); #1;
      n_checks++; if (id_is_vector !== 1'b1 || id_illegal !== 1'b0) begin n_fail++; $display("FAIL vadd_class: got vec=%0h ill=%0h want 1 0", id_is_vector, id_illegal); end
      n_checks++; if (id_reg_write !== 1'b1 || id_rs1 !== 5'd1 || id_rs2 !== 5'd2 || id_funct7 !== 7'h01) begin
         n_fail++; $display("FAIL vadd_fields: got rw=%0h rs1=%0d rs2=%0d f7=%02h want 1 1 2 01", id_reg_write, id_rs1, id_rs2, id_funct7);
      end
      if_instr = 32'hFFFF_FFFF; if_pc = 32'h304;
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1 || id_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_class: got valid=%0h ill=%0h want 1 1", id_valid, id_illegal); end
      n_checks++; if ({id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_is_vector} !== 6'b0) begin
         n_fail++; $display("FAIL ill_flags: got %06b want 000000", {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_is_vector});
      end
      @(posedge clk); #1;
      if_valid = 1'b1; if_instr = 32'h0000_0093; if_pc = 32'h400;
`ifdef ID_ILLEGAL_TRAP_EN
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (if_ready !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL trap_hold[%0d]: got rdy=%0h valid=%0h want 0 0", i, if_ready, id_valid); end
         @(posedge clk); #1;
      end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL trap_no_accept: got %0h want 0", id_valid); end
      flush = 1'b1;
      #1;
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL trap_flush_ready: got %0h want 1", if_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      n_checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL trap_exit: got valid=%0h rdy=%0h want 0 1", id_valid, if_ready); end
`else
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ill_keeps_running: got %0h want 1", if_ready); end
`endif
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h400) begin n_fail++; $display("FAIL after_ill: got valid=%0h pc=%08h want 1 400", id_valid, id_pc); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_full();
      id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h0000_0093; if_pc = 32'h500;
      @(posedge clk); #1;
      if_pc = 32'h504;
      @(posedge clk); #1;
      n_checks++; if (if_ready !== 1'b0 || id_pc !== 32'h500) begin n_fail++; $display("FAIL flush_setup: got rdy=%0h pc=%08h want 0 500", if_ready, id_pc); end
      if_pc = 32'h508; flush = 1'b1;
      #1;
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0h want 1", if_ready); end
      @(posedge clk); #1;
      flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", id_valid); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_quiet[%0d]: got valid=%0h pc=%08h rdy=%0h want 0 - 1", i, id_valid, id_pc, if_ready); end
      end
      if_valid = 1'b1; if_pc = 32'h600;
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h600) begin n_fail++; $display("FAIL flush_next: got valid=%0h pc=%08h want 1 600", id_valid, id_pc); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h0000_0093; if_pc = 32'h700;
      @(posedge clk); #1;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got %0h want 1", id_valid); end
      #1 rst = 1'b0;
      #1;
      n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || if_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_async: got valid=%0h pc=%08h rdy=%0h want 0 0 1", id_valid, id_pc, if_ready);
      end
      @(posedge clk); #1;
      rst = 1'b1; id_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_partial: got %0h want 0", id_valid); end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      clk = 1'b0; rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
      if_instr = 32'h0; if_pc = 32'h0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_immediates();
      test_vector_illegal();
      test_flush_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage directly downstream of instr_fetch in the vector FP core.
- Accepts 32-bit instructions and their PC over a valid/ready handshake.
- Splits each instruction into register fields, generates the sign-extended immediate and classifies it as scalar, vector or illegal.
- Presents a registered decode bundle to the execute/ALU stage through a 2-entry skid buffer, so both handshakes can run at full throughput without a combinational ready path.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and immediate; only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  drop all buffered and incoming instructions (taken jump/branch).
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  decode can accept this cycle.
- if_instr  in  32  raw instruction word.
- if_pc  in  32  PC of if_instr.
- id_valid  out  1  decode bundle valid.
- id_ready  in  1  execute accepts the bundle.
- id_pc  out  32  PC of the decoded instruction.
- id_opcode  out  7  instr[6:0].
- id_rd  out  5  instr[11:7] (full 5 bits).
- id_funct3  out  3  instr[14:12].
- id_rs1  out  5  instr[19:15].
- id_rs2  out  5  instr[24:20].
- id_funct7  out  7  instr[31:25].
- id_imm  out  32  sign-extended immediate.
- id_is_vector  out  1  OP-V (0x57), or LOAD-FP/STORE-FP with width funct3 in {000,101,110,111}.
- id_reg_write  out  1  instruction writes rd.
- id_mem_read  out  1  LOAD or vector/FP load.
- id_mem_write  out  1  STORE or vector/FP store.
- id_branch  out  1  BRANCH.
- id_jump  out  1  JAL or JALR.
- id_illegal  out  1  instruction not recognised.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears both buffer entries and the trap state.
  - id_valid=0 and if_ready=1 at reset; all id_* data outputs are 0.
- Accept and latency:
  - Transfer in occurs when if_valid && if_ready.
  - Decode is combinational on if_instr and registered into the main entry, so id_valid rises exactly 1 cycle after the transfer.
- Skid buffer:
  - The main entry drives the id_* outputs.
  - If a transfer in happens while the main entry is valid and not being consumed (id_valid && !id_ready), the decoded word goes to the skid entry.
  - if_ready = !skid_valid, a registered term.
  - When the main entry is consumed and the skid entry is valid, skid moves into main in the same edge. If a transfer in also happens that edge, the new word fills skid.
  - Order is strictly FIFO.
- Simultaneous in/out with skid empty: the main entry is replaced by the new word and id_valid stays 1. This sustains 1 instruction/cycle.
- Opcode map:
  - Legal: OP 0x33, OP-IMM 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63, JAL 0x6F, JALR 0x67, LUI 0x37, AUIPC 0x17, OP-V 0x57, LOAD-FP 0x07, STORE-FP 0x27.
  - Anything else, or instr[1:0]!=2'b11, sets id_illegal=1 and clears all other control flags.
- Immediates:
  - I-type (OP-IMM, LOAD, JALR, LOAD-FP): sext(instr[31:20]).
  - S-type (STORE, STORE-FP): sext({instr[31:25],instr[11:7]}).
  - B-type: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U-type: {instr[31:12],12'b0}.
  - J-type: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - OP and OP-V: 0.
- reg_write: set for OP, OP-IMM, LOAD, LOAD-FP, JAL, JALR, LUI, AUIPC and OP-V. Cleared when rd==0 for scalar (non-vector) classes.
- Flush:
  - On an edge with flush=1, both entries are cleared, so id_valid=0 next cycle.
  - Any if_valid transfer in the same cycle is discarded.
  - flush takes priority over every other event.
  - if_ready stays 1 during flush, and the incoming word is dropped.
- Reset mid-operation: buffered instructions are lost and no partial bundle is emitted.

Optional Feature:
- Macro ID_ILLEGAL_TRAP_EN.
- With the macro:
  - When an illegal bundle transfers out, decode enters a TRAP state.
  - In TRAP: if_ready=0, id_valid=0, and nothing is accepted.
  - TRAP is left only on flush or reset. Flush returns the block to RUN with empty buffers.
- Without the macro: illegal bundles pass downstream with id_illegal=1 and no control flags set, and decode keeps running.

Test Plan:
- Reset then a single instruction:
  - Stimulus: rst low for 3 cycles, then if_instr=0x00500093 (addi x1,x0,5) at PC 0x0.
  - Required response: one cycle later id_valid=1, id_rd=1, id_imm=5, id_reg_write=1, id_is_vector=0.
- Back-to-back stream with id_ready tied high:
  - Stimulus: 8 instructions on consecutive cycles.
  - Required response: 8 consecutive id_valid cycles, if_ready never drops, PCs 0x0..0x1C in order.
- Backpressure:
  - Stimulus: id_ready=0 while 3 instructions are offered.
  - Required response: 2 are accepted, if_ready=0 on the third. After id_ready=1, the outputs appear in FIFO order with none lost or duplicated.
- Immediate corner cases:
  - Stimulus: beq with offset -4 (0xFE000EE3), and jal with the maximum negative offset.
  - Required response: id_imm=0xFFFFFFFC for the beq; id_imm=0xFFF00000 for the jal.
- Vector and illegal classification:
  - Stimulus: 0x02208057 (vadd.vv), then 0xFFFFFFFF.
  - Required response: id_is_vector=1 for the first; id_illegal=1 for the second. With ID_ILLEGAL_TRAP_EN, if_ready stays 0 until flush.
- Flush with both entries full:
  - Stimulus: flush while both entries are full and if_valid=1.
  - Required response: id_valid=0 next cycle, and none of the 3 instructions ever appears on the output.
